// File: rtl/frac_decim.sv
// Horizontal fractional decimator: accumulates a fractional output position per
// accepted input pixel and writes one blended pixel to the downscaled line
// buffer each time the position crosses an integer boundary.
module frac_decim #(
  parameter int bitwidth    = 10,
  parameter int fracwidth   = 16,
  parameter int colourwidth = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [bitwidth+fracwidth-1:0]   stepsize,
  input  logic [bitwidth-1:0]             offset,
  input  logic [bitwidth-1:0]             limit,
  input  logic                            step_reset,
  input  logic                            step_in,
  input  logic [3*colourwidth-1:0]        pix_in,
  output logic                            wr_en,
  output logic [bitwidth-1:0]             wr_addr,
  output logic [3*colourwidth-1:0]        wr_data,
  output logic                            done
);

  localparam int accwidth = bitwidth + fracwidth;
  localparam int pixwidth = 3 * colourwidth;
  localparam int mixwidth = colourwidth + 2;
  localparam logic [accwidth-1:0] unity = accwidth'(1) << fracwidth;

  logic [accwidth-1:0]  acc;
  logic [bitwidth-1:0]  count;
  logic [bitwidth-1:0]  skip;
  logic [pixwidth-1:0]  prev;

  logic [accwidth-1:0]  step_eff;
  logic [accwidth-1:0]  sum;
  logic                 crossing;
  logic                 accept;
  logic [1:0]           w;
  logic [mixwidth-1:0]  wt_cur;
  logic [mixwidth-1:0]  wt_prev;
  logic [mixwidth-1:0]  cur_ch;
  logic [mixwidth-1:0]  prev_ch;
  logic [mixwidth-1:0]  mix;
  logic [pixwidth-1:0]  blend;
  logic [bitwidth-1:0]  count_next;

  // Next position, crossing detection and the two-tap blend of current and previous pixel
  always_comb begin
    step_eff   = (stepsize > unity) ? unity : stepsize;
    sum        = acc + step_eff;
    crossing   = (sum[accwidth-1:fracwidth] != acc[accwidth-1:fracwidth]);
    accept     = step_in && !step_reset && (skip == '0) && !done;
    count_next = count + bitwidth'(1);
    w          = sum[fracwidth-1 -: 2];
    wt_cur     = mixwidth'(3'd4 - {1'b0, w});
    wt_prev    = mixwidth'(w);
    cur_ch     = '0;
    prev_ch    = '0;
    mix        = '0;
    blend      = '0;
    for (int c = 0; c < 3; c++) begin
      cur_ch  = mixwidth'(pix_in[c*colourwidth +: colourwidth]);
      prev_ch = mixwidth'(prev[c*colourwidth +: colourwidth]);
      mix     = cur_ch * wt_cur + prev_ch * wt_prev;
      blend[c*colourwidth +: colourwidth] = mix[mixwidth-1:2];
    end
  end

  // Line state, skip counter, write-port registers and the limit flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      count   <= '0;
      skip    <= '0;
      prev    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (step_reset) begin
        acc   <= '0;
        count <= '0;
        prev  <= '0;
        skip  <= offset;
        done  <= (limit == '0);
      end else if (step_in && !done && (skip != '0)) begin
        skip <= skip - bitwidth'(1);
      end else if (accept) begin
        acc  <= sum;
        prev <= pix_in;
        if (crossing) begin
          wr_en   <= 1'b1;
          wr_addr <= count;
          wr_data <= blend;
          count   <= count_next;
          if (count_next == limit) begin
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_decim.sv
// Directed-vector bench for frac_decim with hand-computed expected writes.
module tb_frac_decim;

  logic        clk;
  logic        reset;
  logic [25:0] stepsize;
  logic [9:0]  offset;
  logic [9:0]  limit;
  logic        step_reset;
  logic        step_in;
  logic [17:0] pix_in;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [17:0] wr_data;
  logic        done;

  int vectors;
  int miscompares;

  frac_decim dut (
    .clk        (clk),
    .reset      (reset),
    .stepsize   (stepsize),
    .offset     (offset),
    .limit      (limit),
    .step_reset (step_reset),
    .step_in    (step_in),
    .pix_in     (pix_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] grey(input logic [5:0] v);
    return {v, v, v};
  endfunction

  // Drive one cycle of inputs, then settle 1 unit past the edge that sampled them
  task automatic apply_stimulus(input logic si, input logic sr, input logic [17:0] pix);
    step_in    = si;
    step_reset = sr;
    pix_in     = pix;
    @(posedge clk);
    #1;
    step_in    = 1'b0;
    step_reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en); end
    vectors++; if (wr_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    vectors++; if (wr_data !== 18'd0) begin miscompares++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_unity;
    stepsize = 26'h10000; offset = 10'd0; limit = 10'd1023;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 18'(i));
      vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("[TB] FAIL unity_en[%0d]: got %b expected 1", i, wr_en); end
      vectors++; if (wr_addr !== 10'(i-1)) begin miscompares++; $display("[TB] FAIL unity_addr[%0d]: got %0d expected %0d", i, wr_addr, i-1); end
      vectors++; if (wr_data !== 18'(i)) begin miscompares++; $display("[TB] FAIL unity_data[%0d]: got %h expected %h", i, wr_data, i); end
    end
    apply_stimulus(1'b0, 1'b0, 18'h3ffff);
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL unity_idle_en: got %b expected 0", wr_en); end
    vectors++; if (wr_addr !== 10'd4) begin miscompares++; $display("[TB] FAIL unity_hold_addr: got %0d expected 4", wr_addr); end
    vectors++; if (wr_data !== 18'd5) begin miscompares++; $display("[TB] FAIL unity_hold_data: got %h expected 5", wr_data); end
  endtask

  task automatic test_half;
    logic [5:0] in_v [4] = '{6'd10, 6'd20, 6'd30, 6'd40};
    logic       e_en [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0] e_ad [4] = '{10'd0, 10'd0, 10'd0, 10'd1};
    logic [5:0] e_dv [4] = '{6'd0, 6'd20, 6'd0, 6'd40};
    stepsize = 26'h08000; offset = 10'd0; limit = 10'd1023;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, grey(in_v[i]));
      vectors++; if (wr_en !== e_en[i]) begin miscompares++; $display("[TB] FAIL half_en[%0d]: got %b expected %b", i, wr_en, e_en[i]); end
      if (e_en[i]) begin
        vectors++; if (wr_addr !== e_ad[i]) begin miscompares++; $display("[TB] FAIL half_addr[%0d]: got %0d expected %0d", i, wr_addr, e_ad[i]); end
        vectors++; if (wr_data !== grey(e_dv[i])) begin miscompares++; $display("[TB] FAIL half_data[%0d]: got %h expected %h", i, wr_data, grey(e_dv[i])); end
      end
    end
  endtask

  task automatic test_three_quarter;
    logic [5:0] in_v [4] = '{6'd8, 6'd16, 6'd24, 6'd32};
    logic       e_en [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [9:0] e_ad [4] = '{10'd0, 10'd0, 10'd1, 10'd2};
    logic [5:0] e_dv [4] = '{6'd0, 6'd12, 6'd22, 6'd32};
    stepsize = 26'h0C000; offset = 10'd0; limit = 10'd1023;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, grey(in_v[i]));
      vectors++; if (wr_en !== e_en[i]) begin miscompares++; $display("[TB] FAIL tq_en[%0d]: got %b expected %b", i, wr_en, e_en[i]); end
      if (e_en[i]) begin
        vectors++; if (wr_addr !== e_ad[i]) begin miscompares++; $display("[TB] FAIL tq_addr[%0d]: got %0d expected %0d", i, wr_addr, e_ad[i]); end
        vectors++; if (wr_data !== grey(e_dv[i])) begin miscompares++; $display("[TB] FAIL tq_data[%0d]: got %h expected %h", i, wr_data, grey(e_dv[i])); end
      end
    end
  endtask

  task automatic test_offset;
    stepsize = 26'h10000; offset = 10'd3; limit = 10'd1023;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 1'b0, grey(6'(10 + i)));
      if (i < 3) begin
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL offset_skip_en[%0d]: got %b expected 0", i, wr_en); end
      end else begin
        vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("[TB] FAIL offset_en[%0d]: got %b expected 1", i, wr_en); end
        vectors++; if (wr_addr !== 10'(i-3)) begin miscompares++; $display("[TB] FAIL offset_addr[%0d]: got %0d expected %0d", i, wr_addr, i-3); end
        vectors++; if (wr_data !== grey(6'(10 + i))) begin miscompares++; $display("[TB] FAIL offset_data[%0d]: got %h expected %h", i, wr_data, grey(6'(10 + i))); end
      end
    end
  endtask

  task automatic test_limit;
    stepsize = 26'h10000; offset = 10'd0; limit = 10'd2;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL limit_start_done: got %b expected 0", done); end
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, grey(6'(i + 1)));
      vectors++; if (wr_en !== (i < 2)) begin miscompares++; $display("[TB] FAIL limit_en[%0d]: got %b expected %b", i, wr_en, (i < 2)); end
      vectors++; if (done !== (i >= 1)) begin miscompares++; $display("[TB] FAIL limit_done[%0d]: got %b expected %b", i, done, (i >= 1)); end
      if (i < 2) begin
        vectors++; if (wr_addr !== 10'(i)) begin miscompares++; $display("[TB] FAIL limit_addr[%0d]: got %0d expected %0d", i, wr_addr, i); end
      end
    end
    apply_stimulus(1'b0, 1'b1, 18'd0);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL limit_rearm_done: got %b expected 0", done); end
    apply_stimulus(1'b1, 1'b0, grey(6'd33));
    vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("[TB] FAIL limit_rearm_en: got %b expected 1", wr_en); end
    vectors++; if (wr_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL limit_rearm_addr: got %0d expected 0", wr_addr); end
    // Zero limit: done immediately, no writes at all
    limit = 10'd0;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL limit0_done: got %b expected 1", done); end
    apply_stimulus(1'b1, 1'b0, grey(6'd7));
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL limit0_en: got %b expected 0", wr_en); end
  endtask

  task automatic test_step_clamp;
    // Steps above 1.0 act as 1.0; a zero step never crosses
    stepsize = 26'h20000; offset = 10'd0; limit = 10'd1023;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, grey(6'(50 + i)));
      vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("[TB] FAIL clamp_en[%0d]: got %b expected 1", i, wr_en); end
      vectors++; if (wr_addr !== 10'(i)) begin miscompares++; $display("[TB] FAIL clamp_addr[%0d]: got %0d expected %0d", i, wr_addr, i); end
      vectors++; if (wr_data !== grey(6'(50 + i))) begin miscompares++; $display("[TB] FAIL clamp_data[%0d]: got %h expected %h", i, wr_data, grey(6'(50 + i))); end
    end
    stepsize = 26'h0;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, grey(6'd9));
      vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_step_en[%0d]: got %b expected 0", i, wr_en); end
    end
  endtask

  task automatic test_back_to_back;
    stepsize = 26'h10000; offset = 10'd0; limit = 10'd1023;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    apply_stimulus(1'b1, 1'b0, grey(6'd1));
    apply_stimulus(1'b1, 1'b0, grey(6'd2));
    vectors++; if (wr_addr !== 10'd1) begin miscompares++; $display("[TB] FAIL b2b_addr: got %0d expected 1", wr_addr); end
    // step_reset wins over a coincident step_in
    apply_stimulus(1'b1, 1'b1, grey(6'd3));
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL coinc_en: got %b expected 0", wr_en); end
    apply_stimulus(1'b1, 1'b0, grey(6'd4));
    vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("[TB] FAIL coinc_next_en: got %b expected 1", wr_en); end
    vectors++; if (wr_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL coinc_next_addr: got %0d expected 0", wr_addr); end
    vectors++; if (wr_data !== grey(6'd4)) begin miscompares++; $display("[TB] FAIL coinc_next_data: got %h expected %h", wr_data, grey(6'd4)); end
    // Asynchronous reset clears a visible write immediately, without a clock edge
    reset = 1'b1;
    #1;
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL async_en: got %b expected 0", wr_en); end
    vectors++; if (wr_data !== 18'd0) begin miscompares++; $display("[TB] FAIL async_data: got %h expected 0", wr_data); end
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    apply_stimulus(1'b1, 1'b0, grey(6'd5));
    apply_stimulus(1'b1, 1'b0, grey(6'd6));
    vectors++; if (wr_addr !== 10'd1) begin miscompares++; $display("[TB] FAIL pre_async_addr: got %0d expected 1", wr_addr); end
    // Reset asserted while a pixel is being presented: that write never appears
    step_in = 1'b1;
    pix_in  = grey(6'd7);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL async_pending_en: got %b expected 0", wr_en); end
    vectors++; if (wr_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL async_pending_addr: got %0d expected 0", wr_addr); end
    step_in = 1'b0;
    reset   = 1'b0;
    apply_stimulus(1'b0, 1'b1, 18'd0);
    apply_stimulus(1'b1, 1'b0, grey(6'd8));
    vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("[TB] FAIL post_async_en: got %b expected 1", wr_en); end
    vectors++; if (wr_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL post_async_addr: got %0d expected 0", wr_addr); end
    vectors++; if (wr_data !== grey(6'd8)) begin miscompares++; $display("[TB] FAIL post_async_data: got %h expected %h", wr_data, grey(6'd8)); end
  endtask

  // Run every scenario in order, then report
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    stepsize    = '0;
    offset      = '0;
    limit       = '0;
    step_reset  = 1'b0;
    step_in     = 1'b0;
    pix_in      = '0;
    test_reset;
    test_unity;
    test_half;
    test_three_quarter;
    test_offset;
    test_limit;
    test_step_clamp;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
